nonce_sched_ctrl: RTL and testbench

//  Shares the message-authentication sequence counter (existing `counter`) between NUM_REQ

---
 rtl/msg_auth_pkg.sv | 22 ++
 rtl/counter.sv | 37 +++
 rtl/nonce_sched_ctrl_rr_arbiter.sv | 28 ++
 rtl/nonce_sched_ctrl.sv | 168 ++++++++++++++++
 tb/tb_nonce_sched_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/msg_auth_pkg.sv
// Shared types and constants for the message-authentication nonce scheduler.
package msg_auth_pkg;

    localparam int DEFAULT_CNTR_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        EXHAUST = 2'd2
    } sched_state_e;

    // All-ones value of a counter of the given width (saturates at 64 bits).
    function automatic logic [63:0] cntr_max(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

    localparam logic [DEFAULT_CNTR_WIDTH-1:0] CNTR_MAX = '1;

endpackage

// File: rtl/counter.sv
// Sequence counter with an increment enable and a force (load) path that wins over it.
module counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             force_bit,
    input  logic [WIDTH-1:0] force_value,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Force takes priority; otherwise step by one when enabled.
    always_comb begin
        count_d = count_q;
        if (force_bit) begin
            count_d = force_value;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nonce_sched_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, one-hot out.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan requesters starting at the pointer, wrapping around, and keep the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_sched_ctrl.sv
// Nonce scheduler: shares one sequence counter between requesters, handles host
// resync/rekey loads through the counter's force path, and stops issuing at wrap.
module nonce_sched_ctrl
    import msg_auth_pkg::*;
#(
    parameter int CNTR_WIDTH  = DEFAULT_CNTR_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int WARN_MARGIN = 16,
    parameter int MONOTONIC   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [CNTR_WIDTH-1:0] nonce,
    output logic                  nonce_valid,
    input  logic                  load_valid,
    input  logic [CNTR_WIDTH-1:0] load_value,
    output logic                  load_ack,
    output logic                  load_err,
    output logic                  near_wrap,
    output logic                  exhausted
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNTR_WIDTH-1:0] MAX_VAL     = CNTR_WIDTH'(cntr_max(CNTR_WIDTH));
    localparam logic [CNTR_WIDTH-1:0] WARN_THRESH = MAX_VAL - CNTR_WIDTH'(WARN_MARGIN);

    sched_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [CNTR_WIDTH-1:0] nonce_q, nonce_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNTR_WIDTH-1:0] load_val_q, load_val_d;
    logic                  load_ack_q, load_ack_d;
    logic                  load_err_q, load_err_d;
    logic                  near_wrap_q, near_wrap_d;
    logic                  exhausted_q, exhausted_d;

    logic [CNTR_WIDTH-1:0] count;
    logic [CNTR_WIDTH-1:0] eff_count;
    logic                  cnt_enable;
    logic                  cnt_force;
    logic [CNTR_WIDTH-1:0] cnt_force_value;
    logic [NUM_REQ-1:0]    arb_grant;
    logic                  load_take;
    logic                  load_ok;

    counter #(
        .WIDTH(CNTR_WIDTH)
    ) u_counter (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (cnt_enable),
        .force_bit  (cnt_force),
        .force_value(cnt_force_value),
        .count      (count)
    );

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .PTR_W  (PTR_W)
    ) u_arbiter (
        .req  (req_valid),
        .ptr  (ptr_q),
        .grant(arb_grant)
    );

    // Counter controls and the counter value that will be visible next cycle; a grant
    // in flight bumps the counter at this edge, so decisions use the post-increment value.
    always_comb begin
        cnt_enable      = |gnt_q;
        cnt_force       = (state_q == LOAD);
        cnt_force_value = load_val_q;
        eff_count       = count + CNTR_WIDTH'(cnt_enable);
        load_take       = load_valid && (state_q != LOAD);
        load_ok         = load_take &&
                          ((MONOTONIC == 0) || (state_q == EXHAUST) || (load_value >= eff_count));
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: loads win over everything, reaching MAX parks the scheduler.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (load_ok) begin
                    state_d = LOAD;
                end else if (!load_take && (eff_count == MAX_VAL)) begin
                    state_d = EXHAUST;
                end
            end
            LOAD: begin
                state_d = (load_val_q == MAX_VAL) ? EXHAUST : RUN;
            end
            EXHAUST: begin
                if (load_ok) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs for next cycle: grant only in RUN with no load and headroom left.
    always_comb begin
        gnt_d       = '0;
        nonce_d     = '0;
        ptr_d       = ptr_q;
        load_ack_d  = load_ok;
        load_err_d  = load_take && !load_ok;
        load_val_d  = load_ok ? load_value : load_val_q;
        near_wrap_d = (count >= WARN_THRESH);
        exhausted_d = (state_d == EXHAUST);
        if ((state_q == RUN) && !load_take && (eff_count != MAX_VAL)) begin
            gnt_d = arb_grant;
        end
        if (|gnt_d) begin
            nonce_d = eff_count;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_d[i]) begin
                ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Registered outputs and bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt_q       <= '0;
            nonce_q     <= '0;
            ptr_q       <= '0;
            load_val_q  <= '0;
            load_ack_q  <= 1'b0;
            load_err_q  <= 1'b0;
            near_wrap_q <= 1'b0;
            exhausted_q <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            nonce_q     <= nonce_d;
            ptr_q       <= ptr_d;
            load_val_q  <= load_val_d;
            load_ack_q  <= load_ack_d;
            load_err_q  <= load_err_d;
            near_wrap_q <= near_wrap_d;
            exhausted_q <= exhausted_d;
        end
    end

    assign gnt         = gnt_q;
    assign nonce       = nonce_q;
    assign nonce_valid = |gnt_q;
    assign load_ack    = load_ack_q;
    assign load_err    = load_err_q;
    assign near_wrap   = near_wrap_q;
    assign exhausted   = exhausted_q;

endmodule

// File: tb/tb_nonce_sched_ctrl.sv
// Testbench for nonce_sched_ctrl: cycle model feeding a scoreboard, plus directed checks.
module tb_nonce_sched_ctrl;

    localparam logic [31:0] MAX    = 32'hFFFF_FFFF;
    localparam logic [31:0] THRESH = 32'hFFFF_FFFF - 32'd16;
    localparam int S_RUN  = 0;
    localparam int S_LOAD = 1;
    localparam int S_EXH  = 2;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [31:0] nonce;
        logic        ack;
        logic        err;
        logic        near;
        logic        exh;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic        load_valid;
    logic [31:0] load_value;

    logic [3:0]  gnt,  nm_gnt;
    logic [31:0] nonce, nm_nonce;
    logic        nonce_valid, nm_nonce_valid;
    logic        load_ack, nm_load_ack;
    logic        load_err, nm_load_err;
    logic        near_wrap, nm_near_wrap;
    logic        exhausted, nm_exhausted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ack    = 0;
    int n_err    = 0;

    exp_t        exp_q[$];
    logic [3:0]  seen_gnt[$];
    logic [31:0] seen_nonce[$];

    logic [31:0] m_cnt;
    logic [31:0] m_loadval;
    int          m_state;
    int          m_ptr;
    logic [3:0]  m_gnt;
    exp_t        e_m;
    exp_t        e_c;

    nonce_sched_ctrl #(
        .CNTR_WIDTH(32), .NUM_REQ(4), .WARN_MARGIN(16), .MONOTONIC(1)
    ) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .gnt(gnt), .nonce(nonce),
        .nonce_valid(nonce_valid), .load_valid(load_valid), .load_value(load_value),
        .load_ack(load_ack), .load_err(load_err), .near_wrap(near_wrap), .exhausted(exhausted)
    );

    nonce_sched_ctrl #(
        .CNTR_WIDTH(32), .NUM_REQ(4), .WARN_MARGIN(16), .MONOTONIC(0)
    ) dut_nm (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .gnt(nm_gnt), .nonce(nm_nonce),
        .nonce_valid(nm_nonce_valid), .load_valid(load_valid), .load_value(load_value),
        .load_ack(nm_load_ack), .load_err(nm_load_err), .near_wrap(nm_near_wrap),
        .exhausted(nm_exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: at each edge work out what the scheduler must show next cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt     = '0;
            m_loadval = '0;
            m_state   = S_RUN;
            m_ptr     = 0;
            m_gnt     = '0;
            exp_q.delete();
        end else begin
            e_m      = '0;
            e_m.near = (m_cnt >= THRESH);
            if (m_state == S_LOAD) m_cnt = m_loadval;
            else if (m_gnt != 4'b0000) m_cnt = m_cnt + 32'd1;
            if (m_state == S_LOAD) begin
                m_state = (m_loadval == MAX) ? S_EXH : S_RUN;
            end else if (load_valid) begin
                if ((m_state == S_EXH) || (load_value >= m_cnt)) begin
                    e_m.ack   = 1'b1;
                    m_loadval = load_value;
                    m_state   = S_LOAD;
                end else begin
                    e_m.err = 1'b1;
                end
            end else if (m_state == S_RUN) begin
                if (m_cnt == MAX) begin
                    m_state = S_EXH;
                end else if (req_valid != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (e_m.gnt == 4'b0000 && req_valid[(m_ptr + k) % 4]) begin
                            e_m.gnt[(m_ptr + k) % 4] = 1'b1;
                            e_m.nonce = m_cnt;
                            m_ptr = (m_ptr + k + 1) % 4;
                        end
                    end
                end
            end
            m_gnt   = e_m.gnt;
            e_m.exh = (m_state == S_EXH);
            exp_q.push_back(e_m);
        end
    end

    // Scoreboard: compare DUT outputs mid-cycle and log issued nonces for directed checks.
    always @(negedge clk) begin
        if (resetn && exp_q.size() > 0) begin
            e_c = exp_q.pop_front();
            check_output("gnt",         64'(gnt),         64'(e_c.gnt));
            check_output("nonce",       64'(nonce),       64'(e_c.nonce));
            check_output("nonce_valid", 64'(nonce_valid), 64'(|e_c.gnt));
            check_output("load_ack",    64'(load_ack),    64'(e_c.ack));
            check_output("load_err",    64'(load_err),    64'(e_c.err));
            check_output("near_wrap",   64'(near_wrap),   64'(e_c.near));
            check_output("exhausted",   64'(exhausted),   64'(e_c.exh));
            if (nonce_valid) begin
                seen_gnt.push_back(gnt);
                seen_nonce.push_back(nonce);
            end
            if (load_ack) n_ack++;
            if (load_err) n_err++;
        end
    end

    // Directed stimulus sequence.
    initial begin
        logic [3:0] one_hot;
        resetn     = 1'b0;
        req_valid  = '0;
        load_valid = 1'b0;
        load_value = '0;
        #2;
        check_output("rst_gnt",   64'(gnt),         64'd0);
        check_output("rst_nonce", 64'(nonce),       64'd0);
        check_output("rst_nv",    64'(nonce_valid), 64'd0);
        check_output("rst_ack",   64'(load_ack),    64'd0);
        check_output("rst_err",   64'(load_err),    64'd0);
        check_output("rst_near",  64'(near_wrap),   64'd0);
        check_output("rst_exh",   64'(exhausted),   64'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        tick(1);

        // All four requesting: strict rotation, consecutive nonces from 0.
        seen_gnt.delete(); seen_nonce.delete();
        req_valid = 4'b1111;
        tick(8);
        req_valid = 4'b0000;
        tick(2);
        check_output("t1_count", 64'(seen_nonce.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            one_hot = 4'b0001 << (k % 4);
            check_output($sformatf("t1_gnt%0d", k),   64'(seen_gnt[k]),   64'(one_hot));
            check_output($sformatf("t1_nonce%0d", k), 64'(seen_nonce[k]), 64'(k));
        end

        // Two requesters alternate without gaps, then reset mid-burst.
        seen_gnt.delete(); seen_nonce.delete();
        req_valid = 4'b0101;
        tick(6);
        #1 resetn = 1'b0;
        #1;
        check_output("t2_rst_gnt",   64'(gnt),         64'd0);
        check_output("t2_rst_nonce", 64'(nonce),       64'd0);
        check_output("t2_rst_nv",    64'(nonce_valid), 64'd0);
        check_output("t2_rst_exh",   64'(exhausted),   64'd0);
        check_output("t2_count", 64'(seen_nonce.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            one_hot = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            check_output($sformatf("t2_gnt%0d", k),   64'(seen_gnt[k]),   64'(one_hot));
            check_output($sformatf("t2_nonce%0d", k), 64'(seen_nonce[k]), 64'(8 + k));
        end
        seen_gnt.delete(); seen_nonce.delete();
        @(posedge clk);
        #3 resetn = 1'b1;
        tick(3);
        req_valid = 4'b0000;
        tick(2);
        check_output("t2_restart_count", 64'(seen_nonce.size()), 64'd3);
        check_output("t2_restart_nonce", 64'(seen_nonce[0]),     64'd0);
        check_output("t2_restart_gnt",   64'(seen_gnt[0]),       64'd1);

        // Forward load beats a pending request; a backward load is rejected.
        seen_gnt.delete(); seen_nonce.delete(); n_ack = 0; n_err = 0;
        req_valid  = 4'b0001;
        load_valid = 1'b1;
        load_value = 32'h100;
        tick(1);
        load_valid = 1'b0;
        tick(2);
        req_valid  = 4'b0000;
        load_valid = 1'b1;
        load_value = 32'h10;
        tick(1);
        load_valid = 1'b0;
        req_valid  = 4'b0001;
        tick(1);
        req_valid  = 4'b0000;
        tick(2);
        check_output("t3_count",  64'(seen_nonce.size()), 64'd2);
        check_output("t3_nonce0", 64'(seen_nonce[0]),     64'h100);
        check_output("t3_nonce1", 64'(seen_nonce[1]),     64'h101);
        check_output("t3_acks",   64'(n_ack),             64'd1);
        check_output("t3_errs",   64'(n_err),             64'd1);

        // Approach MAX: last three nonces issued, then exhausted with request held.
        seen_gnt.delete(); seen_nonce.delete();
        load_valid = 1'b1;
        load_value = MAX - 32'd3;
        req_valid  = 4'b0001;
        tick(1);
        load_valid = 1'b0;
        tick(7);
        check_output("t4_exh",   64'(exhausted),   64'd1);
        check_output("t4_gnt",   64'(gnt),         64'd0);
        check_output("t4_nv",    64'(nonce_valid), 64'd0);
        check_output("t4_near",  64'(near_wrap),   64'd1);
        check_output("t4_count", 64'(seen_nonce.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("t4_nonce%0d", k), 64'(seen_nonce[k]), 64'(MAX - 32'd3 + 32'(k)));
        end

        // Rekey out of exhaustion; the held request is then served.
        seen_gnt.delete(); seen_nonce.delete();
        load_valid = 1'b1;
        load_value = 32'h5;
        tick(1);
        load_valid = 1'b0;
        check_output("t5_ack", 64'(load_ack),  64'd1);
        check_output("t5_exh", 64'(exhausted), 64'd0);
        tick(2);
        req_valid = 4'b0000;
        tick(2);
        check_output("t5_count", 64'(seen_nonce.size()), 64'd1);
        check_output("t5_nonce", 64'(seen_nonce[0]),     64'h5);
        check_output("t5_gnt",   64'(seen_gnt[0]),       64'd1);

        // Non-monotonic build accepts a backward load; load during LOAD is ignored.
        load_valid = 1'b1;
        load_value = 32'h200;
        tick(1);
        check_output("t6_nm_ack_fwd", 64'(nm_load_ack), 64'd1);
        load_value = 32'h300;
        tick(1);
        load_valid = 1'b0;
        check_output("t6_ign_ack",    64'(load_ack),    64'd0);
        check_output("t6_ign_err",    64'(load_err),    64'd0);
        check_output("t6_nm_ign_ack", 64'(nm_load_ack), 64'd0);
        tick(1);
        load_valid = 1'b1;
        load_value = 32'h10;
        tick(1);
        load_valid = 1'b0;
        check_output("t6_nm_ack", 64'(nm_load_ack), 64'd1);
        check_output("t6_nm_err", 64'(nm_load_err), 64'd0);
        check_output("t6_m_err",  64'(load_err),    64'd1);
        tick(1);
        req_valid = 4'b0001;
        tick(1);
        check_output("t6_nm_nonce", 64'(nm_nonce),       64'h10);
        check_output("t6_nm_nv",    64'(nm_nonce_valid), 64'd1);
        check_output("t6_m_nonce",  64'(nonce),          64'h200);
        req_valid = 4'b0000;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
